// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front end: sequential PC issue to imem, DEPTH-entry {code,pc} queue toward decode,
// redirect flush with late-response discard. Optional macro FETCH_STATS_EN adds pop/stall counters.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] MAX_OST  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [31:0]      fetch_pc_r;
  logic [31:0]      resp_pc_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [31:0]      mem_code_r [DEPTH];
  logic [31:0]      mem_pc_r   [DEPTH];
  logic [31:0]      hold_code_r;
  logic [31:0]      hold_pc_r;

  logic [CNT_W:0]   credit_sum_s;
  logic             accept_s;
  logic             discard_s;
  logic             push_s;
  logic             pop_s;
  logic             queue_nonempty_s;
  logic [31:0]      redirect_base_s;
  logic             unused_pc_bits_s;

  // Issue credit, response/pop qualification and head presentation.
  always_comb begin
    credit_sum_s     = {1'b0, count_r} + {1'b0, outstanding_r};
    queue_nonempty_s = (count_r != CNT_ZERO);
    redirect_base_s  = {redirect_pc[31:2], 2'b00};
    unused_pc_bits_s = ^redirect_pc[1:0];
    imem_req         = rst & ~redirect_valid & (outstanding_r < MAX_OST) & (credit_sum_s < DEPTH_W);
    imem_addr        = fetch_pc_r;
    accept_s         = imem_req & imem_ready;
    discard_s        = imem_rvalid & (drop_cnt_r != CNT_ZERO);
    push_s           = rst & imem_rvalid & ~discard_s & ~redirect_valid;
    inst_valid       = rst & queue_nonempty_s & ~redirect_valid;
    pop_s            = inst_valid & inst_ready;
    if (!rst) begin
      inst_code = 32'h0000_0000;
      inst_pc   = 32'h0000_0000;
    end else if (queue_nonempty_s) begin
      inst_code = mem_code_r[rd_ptr_r];
      inst_pc   = mem_pc_r[rd_ptr_r];
    end else begin
      inst_code = hold_code_r;
      inst_pc   = hold_pc_r;
    end
  end

  // PCs, credit counters, discard counter and queue pointers; redirect overrides push/pop/issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      count_r       <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r    <= redirect_base_s;
      resp_pc_r     <= redirect_base_s;
      count_r       <= CNT_ZERO;
      wr_ptr_r      <= rd_ptr_r;
      // Everything still in flight, minus a response landing now, belongs to the old stream.
      outstanding_r <= outstanding_r - CNT_W'(imem_rvalid);
      drop_cnt_r    <= outstanding_r - CNT_W'(imem_rvalid);
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + PTR_ONE;
        resp_pc_r <= resp_pc_r + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (discard_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      case ({accept_s, imem_rvalid})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; written only on an accepted (non-discarded) response.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_code_r[wr_ptr_r] <= imem_rdata;
      mem_pc_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

  // Last head shown to decode, kept on the outputs while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_code_r <= 32'h0000_0000;
      hold_pc_r   <= 32'h0000_0000;
    end else if (inst_valid) begin
      hold_code_r <= inst_code;
      hold_pc_r   <= inst_pc;
    end
  end

`ifdef FETCH_STATS_EN
  // Pop and stall statistics; free-running, wrap at 2^32, untouched by redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fetched <= 32'h0000_0000;
      stat_stall   <= 32'h0000_0000;
    end else begin
      if (pop_s) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (!inst_valid) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

  inst_prefetch_queue_chk #(
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .count      (count_r),
    .outstanding(outstanding_r),
    .drop_cnt   (drop_cnt_r)
  );

endmodule

// Structural invariants of the prefetch queue credit scheme.
module inst_prefetch_queue_chk #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] count,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] drop_cnt
);

  ap_count_le_depth: assert property (@(posedge clk) disable iff (!rst)
    count <= CNT_W'(DEPTH));

  ap_outstanding_le_max: assert property (@(posedge clk) disable iff (!rst)
    outstanding <= CNT_W'(MAX_OUTSTANDING));

  ap_credit_le_depth: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, count} + {1'b0, outstanding}) <= (CNT_W+1)'(DEPTH));

  ap_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst)
    drop_cnt <= outstanding);

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue against a queue-based reference model, plus a second
// instance with RESET_PC near the top of the address space to exercise PC wrap.
module tb_inst_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_code, inst_pc;

  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_code, w_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stall, w_stat_fetched, unused_w_stat_stall;
`endif

  inst_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_code(inst_code), .inst_pc(inst_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
  );

  inst_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .inst_valid(w_valid), .inst_ready(1'b1), .inst_code(w_code), .inst_pc(w_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(w_stat_fetched), .stat_stall(unused_w_stat_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct packed { logic [31:0] code; logic [31:0] pc; } entry_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;

  // Reference model state
  entry_t      q[$];
  pend_t       pend[$];
  logic [31:0] m_fetch = 32'h0, m_resp = 32'h0;
  logic [31:0] m_last_code = 32'h0, m_last_pc = 32'h0;
  logic [31:0] m_fetched = 32'h0, m_stall = 32'h0;
  int          m_outst = 0, m_drop = 0;
  logic [31:0] cyc = 32'h0;

  // Wrap-instance responder and tracking
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = 32'h0;
  int          w_seen = 0;

  // Stimulus knobs
  int          lat_min = 1, lat_max = 1, ready_pct = 100, iready_pct = 100, redir_pct = 0;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;
  int          rel_cyc = 0, first_valid = -1;

  task automatic run(input int n);
    logic   exp_req, exp_valid, acc, w_req_q;
    logic [31:0] w_addr_q, lat;
    entry_t e;
    pend_t  p;
    for (int i = 0; i < n; i++) begin
      imem_ready  = ($urandom_range(99) < ready_pct);
      imem_rvalid = (pend.size() != 0) && (pend[0].due <= cyc);
      imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : $urandom;
      inst_ready  = ($urandom_range(99) < iready_pct);
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_pc;
      end else begin
        redirect_valid = ($urandom_range(99) < redir_pct);
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      end
      w_rvalid = w_pend;
      w_rdata  = mem_word(w_pend_addr);

      exp_req   = rst && !redirect_valid && (m_outst < MAXO) && ((q.size() + m_outst) < DEPTH);
      exp_valid = rst && (q.size() != 0) && !redirect_valid;
      #3;
      check_val("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
      if (exp_req) check_val("imem_addr", imem_addr, m_fetch);
      check_val("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
      if (!rst) begin
        check_val("reset_inst_code", inst_code, 32'h0);
        check_val("reset_inst_pc", inst_pc, 32'h0);
      end else if (exp_valid) begin
        check_val("inst_code", inst_code, q[0].code);
        check_val("inst_pc", inst_pc, q[0].pc);
        if (first_valid < 0) first_valid = rel_cyc;
      end else if (q.size() == 0) begin
        check_val("hold_inst_code", inst_code, m_last_code);
        check_val("hold_inst_pc", inst_pc, m_last_pc);
      end
`ifdef FETCH_STATS_EN
      if (cyc > 0) begin
        check_val("stat_fetched", stat_fetched, m_fetched);
        check_val("stat_stall", stat_stall, m_stall);
        if (rst) check_val("w_stat_fetched", w_stat_fetched, 32'(w_seen));
      end
`endif
      if (rst && w_valid) begin
        check_val("wrap_inst_pc", w_pc, WRAP_PC + 32'(4 * w_seen));
        check_val("wrap_inst_code", w_code, mem_word(WRAP_PC + 32'(4 * w_seen)));
        w_seen++;
      end
      w_req_q  = w_req;
      w_addr_q = w_addr;

      @(posedge clk);
      acc = exp_req && imem_ready;
      if (!rst) begin
        q.delete();
        pend.delete();
        m_fetch = 32'h0; m_resp = 32'h0;
        m_outst = 0; m_drop = 0;
        m_last_code = 32'h0; m_last_pc = 32'h0;
        m_fetched = 32'h0; m_stall = 32'h0;
        w_pend = 1'b0; w_seen = 0;
        rel_cyc = 0;
      end else begin
        w_pend      = w_req_q;
        w_pend_addr = w_addr_q;
        rel_cyc++;
        if (exp_valid) begin
          m_last_code = q[0].code;
          m_last_pc   = q[0].pc;
        end else begin
          m_stall++;
        end
        if (imem_rvalid) void'(pend.pop_front());
        if (acc) begin
          lat    = 32'($urandom_range(lat_max, lat_min));
          p.addr = m_fetch;
          p.due  = cyc + lat;
          pend.push_back(p);
        end
        if (redirect_valid) begin
          q.delete();
          m_fetch = {redirect_pc[31:2], 2'b00};
          m_resp  = m_fetch;
          m_drop  = m_outst - (imem_rvalid ? 1 : 0);
          m_outst = m_drop;
        end else begin
          if (exp_valid && inst_ready) begin
            void'(q.pop_front());
            m_fetched++;
          end
          if (imem_rvalid) begin
            if (m_drop > 0) begin
              m_drop--;
            end else begin
              e.code = imem_rdata;
              e.pc   = m_resp;
              q.push_back(e);
              m_resp += 32'd4;
            end
            m_outst--;
          end
          if (acc) begin
            m_fetch += 32'd4;
            m_outst++;
          end
        end
      end
      cyc++;
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    w_rvalid = 1'b0; w_rdata = 32'h0;
    #1;
    run(3);

    // Streaming with single-cycle memory; first instruction two cycles after reset release
    rst = 1'b1; first_valid = -1;
    run(20);
    check_val("first_inst_latency", 32'(first_valid), 32'd2);

    // Backpressure fills the queue, then release drains it in order
    iready_pct = 0;   run(10);
    iready_pct = 100; run(10);

    // Redirect with two requests in flight on a slow memory
    lat_min = 3; lat_max = 3; run(6);
    force_redir = 1'b1; force_pc = 32'h0000_0103; run(1);
    force_redir = 1'b0; run(12);

    // Redirect near the top of the address space
    lat_min = 1; lat_max = 1;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF4; run(1);
    force_redir = 1'b0; run(10);

    // Random traffic
    lat_min = 1; lat_max = 4; ready_pct = 70; iready_pct = 60; redir_pct = 4;
    run(2000);

    // Reset with a full queue, then restart
    lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 0; redir_pct = 0;
    run(10);
    rst = 1'b0; run(2);
    rst = 1'b1; iready_pct = 100; run(20);

    lat_min = 1; lat_max = 5; ready_pct = 50; iready_pct = 75; redir_pct = 8;
    run(1000);

    check_val("wrap_progress", {31'h0, (w_seen >= 3)}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
